router_reg_param: RTL and testbench
===================================

# router_reg_param

Parametrised packet datapath register for the router: holds the header byte, forwards payload bytes to the selected output FIFO, buffers bytes arriving while the FIFO is full, and checks parity and packet length. Sits between the router input port and the three output FIFOs. It is driven by the router FSM's state strobes.

## Interface
- DATA_W, 8: byte width. Must be ≥ 4.
- SKID_DEPTH, 2: number of bytes buffered while `fifo_full` is high (1..4).
- PARITY_MODE, 0: check type. 0 = bitwise XOR of header, payload and parity byte must be zero. 1 = sum mod 2^DATA_W of header and payload must equal the parity byte.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- pkt_valid  in  1  source byte valid; a falling edge marks the parity byte.
- data_in  in  DATA_W  input byte. Header layout: [1:0] = address, [DATA_W-1:2] = payload length L.
- fifo_full  in  1  selected output FIFO cannot accept a write this cycle.
- rst_int_reg, detect_add, ld_state, laf_state, full_state, lfd_state  in  1 each  FSM strobes. At most one of the state strobes is high in a cycle.
- dout  out  DATA_W  byte to FIFO.
- dout_we  out  1  `dout` is valid this cycle.
- parity_done, low_pkt_valid, error, len_error  out  1  status flags.
- skid_count  out  $clog2(SKID_DEPTH+1)  bytes currently held in the skid buffer.

## Operation
- Header capture: `detect_add & pkt_valid` latches `data_in` into `hdr`. It also clears the check accumulator, the length counter, `error`, `len_error` and `parity_done`.
- LFD: `lfd_state` drives `dout <= hdr` and `dout_we <= 1`. It also folds `hdr` into the accumulator.
- LD, `ld_state & pkt_valid`, payload byte handling:
  - If `!fifo_full` and the skid buffer is empty: `dout <= data_in`, `dout_we <= 1`.
  - Otherwise the byte is pushed into the skid buffer, which is a circular buffer.
  - In both cases the byte is folded into the accumulator (XOR or add, per PARITY_MODE) and the length counter increments. The counter saturates at 2^(DATA_W-2)-1.
- LD, `ld_state & !pkt_valid`: `data_in` is the parity byte. It is latched into `pkt_par` and is never written to the FIFO or folded into the accumulator. `low_pkt_valid` is set.
- LAF or FULL: while the skid buffer is non-empty and `!fifo_full`, pop one byte per cycle to `dout` with `dout_we = 1`, in FIFO order.
- Push and pop in the same cycle are legal; `skid_count` stays the same.
- Skid overflow (push with `skid_count == SKID_DEPTH` and no pop): the byte is dropped, the count does not change, and `error` is set.
- Check: in the cycle after `pkt_par` is latched, `parity_done <= 1` for exactly one cycle.
  - `error` is set in that same cycle if the check fails.
  - `len_error` is set if the length counter ≠ L.
  - `error` and `len_error` are sticky until the next header capture or reset.
- `rst_int_reg` clears `low_pkt_valid`. If it is asserted in the same cycle as the set condition, the set wins.
- Reset mid-packet: all state, the skid buffer, the counters and the flags clear in one cycle. Bytes still in the skid buffer are discarded.

## Timing
- Reset values: `dout = 0`, `dout_we = 0`, `parity_done = 0`, `low_pkt_valid = 0`, `error = 0`, `len_error = 0`, `skid_count = 0`. Internal `hdr`, `pkt_par` and the accumulator are also 0.
- All outputs are registered. A byte presented at edge n appears on `dout` with `dout_we` after edge n; latency is 1 cycle.
- A skidded byte appears 1 cycle after the edge on which LAF or FULL sees `!fifo_full`.
- `parity_done`, `error` and `len_error` are valid together, 2 cycles after the parity byte edge.
- `dout_we` is low in every cycle where no write occurs. `dout` holds its last value.

## Structure
- Shared package `router_pkg`:
  - parity mode constants `PAR_XOR = 0` and `PAR_SUM = 1`;
  - header field widths and offsets (`ADDR_W = 2`, `LEN_LSB = 2`);
  - the check-fold function, selected by mode.
- One sub-module: `router_skid_buf` (parametrised DATA_W and SKID_DEPTH). It owns the read pointer, write pointer, count, and push/pop/overflow logic.
- The rest (header capture, accumulator, length counter, flags) stays in the top level.

## Test plan
- PARITY_MODE=0: header 8'h0D (L=3, addr 1), payload 11,22,33, correct XOR parity 8'h0D^11^22^33 -> dout sequence 0D,11,22,33, `parity_done` pulse, `error = 0`, `len_error = 0`.
- Same packet with parity byte off by one bit -> `error = 1` with `parity_done`; `error` stays 1 until the next `detect_add`.
- Header L=4 but only 3 payload bytes -> `len_error = 1` and `error = 0`.
- SKID_DEPTH=2: `fifo_full` high for 2 payload bytes, then LAF with `!fifo_full` -> `skid_count` 1, 2, 1, 0. The two bytes are popped in order, and no byte is lost.
- SKID_DEPTH=2: three bytes arrive while full -> third byte dropped, `skid_count` stays 2, `error = 1`.
- PARITY_MODE=1, with `rst` asserted low mid-payload -> all outputs 0 on the next cycle. The following clean packet with parity = sum mod 256 passes with `error = 0`.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router datapath: header layout, parity check
// modes and the accumulator fold used by the packet check.
package router_pkg;

  // Parity check modes
  localparam int PAR_XOR = 0;
  localparam int PAR_SUM = 1;

  // Header layout: address in the low bits, payload length above it
  localparam int ADDR_W  = 2;
  localparam int LEN_LSB = 2;

  // Working width of the fold; callers truncate to their byte width, which
  // gives the mod 2^DATA_W behaviour for the sum mode for free.
  localparam int FOLD_W = 32;

  // Source of the next byte written towards the output FIFO
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_HDR    = 2'd1,
    SRC_DIRECT = 2'd2,
    SRC_SKID   = 2'd3
  } dout_src_e;

  // Fold one byte into the running check value
  function automatic logic [FOLD_W-1:0] par_fold(
    input int                mode,
    input logic [FOLD_W-1:0] acc,
    input logic [FOLD_W-1:0] b
  );
    if (mode == PAR_SUM) begin
      return acc + b;
    end
    return acc ^ b;
  endfunction

  // Final check: XOR mode needs acc ^ parity == 0, SUM mode needs acc == parity
  function automatic logic par_ok(
    input int                mode,
    input logic [FOLD_W-1:0] acc,
    input logic [FOLD_W-1:0] par
  );
    if (mode == PAR_SUM) begin
      return acc == par;
    end
    return (acc ^ par) == '0;
  endfunction

endpackage

// File: rtl/router_reg_param_if.sv
// Byte-stream bus between the router input port / FSM and the datapath
// register. The master side drives bytes and state strobes, the slave side
// returns the FIFO write and the status flags.
interface router_reg_param_if #(
  parameter int DATA_W     = 8,
  parameter int SKID_DEPTH = 2
);
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              rst_int_reg;
  logic              detect_add;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              lfd_state;

  logic [DATA_W-1:0] dout;
  logic              dout_we;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              error;
  logic              len_error;
  logic [CNT_W-1:0]  skid_count;

  modport master (
    output pkt_valid, data_in, fifo_full, rst_int_reg, detect_add,
           ld_state, laf_state, full_state, lfd_state,
    input  dout, dout_we, parity_done, low_pkt_valid, error, len_error,
           skid_count
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, rst_int_reg, detect_add,
           ld_state, laf_state, full_state, lfd_state,
    output dout, dout_we, parity_done, low_pkt_valid, error, len_error,
           skid_count
  );

endinterface

// File: rtl/router_skid_buf.sv
// Small circular buffer holding payload bytes that arrive while the output
// FIFO is full. Pops on an empty buffer are ignored; pushes into a full
// buffer without a simultaneous pop are dropped and flagged.
module router_skid_buf #(
  parameter  int DATA_W     = 8,
  parameter  int SKID_DEPTH = 2,
  localparam int CNT_W      = $clog2(SKID_DEPTH + 1),
  localparam int PTR_W      = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o,
  output logic              overflow_o
);

  logic [DATA_W-1:0] mem_q [SKID_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full;
  logic              pop_ok;
  logic              push_ok;

  // Pointer advance with wrap at the configured depth (depth need not be 2^n)
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(SKID_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign full       = (count_q == CNT_W'(SKID_DEPTH));
  assign empty_o    = (count_q == '0);
  assign pop_ok     = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push needs
  assign push_ok    = push_i & (~full | pop_ok);
  assign overflow_o = push_i & full & ~pop_ok;
  assign rdata_o    = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Next pointer and occupancy values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the buffer
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care once the count says empty
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/router_reg_param.sv
// Router packet datapath register: captures the header, forwards header and
// payload to the selected output FIFO, parks bytes in a skid buffer while the
// FIFO is full, and checks parity and payload length at the end of a packet.
module router_reg_param
  import router_pkg::*;
#(
  parameter int DATA_W      = 8,   // byte width, at least 4
  parameter int SKID_DEPTH  = 2,   // 1..4
  parameter int PARITY_MODE = 0    // PAR_XOR or PAR_SUM
) (
  input logic               clk,
  input logic               rst,
  router_reg_param_if.slave bus
);

  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int LEN_W = DATA_W - LEN_LSB;

  // Datapath registers
  logic [DATA_W-1:0] hdr_q, hdr_d;
  logic [DATA_W-1:0] pkt_par_q, pkt_par_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              chk_pend_q, chk_pend_d;

  // Registered outputs
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_we_q, dout_we_d;
  logic              parity_done_q, parity_done_d;
  logic              low_pkt_valid_q, low_pkt_valid_d;
  logic              error_q, error_d;
  logic              len_error_q, len_error_d;

  // Strobe decode
  logic              hdr_cap;
  logic              ld_byte;
  logic              ld_par;
  logic              drain;
  logic              direct;
  logic              push;
  logic              pop;
  dout_src_e         dout_src;

  // Skid buffer interface
  logic [DATA_W-1:0] skid_rdata;
  logic [CNT_W-1:0]  skid_count;
  logic              skid_empty;
  logic              skid_ovf;

  // Fold at byte width; the cast keeps only the low DATA_W bits
  function automatic logic [DATA_W-1:0] fold(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    return DATA_W'(par_fold(PARITY_MODE, FOLD_W'(a), FOLD_W'(b)));
  endfunction

  assign hdr_cap = bus.detect_add & bus.pkt_valid;
  assign ld_byte = bus.ld_state & bus.pkt_valid;
  assign ld_par  = bus.ld_state & ~bus.pkt_valid;
  assign drain   = bus.laf_state | bus.full_state;
  // Bytes go straight out only if nothing older is waiting, to keep order
  assign direct  = ld_byte & ~bus.fifo_full & skid_empty;
  assign push    = ld_byte & ~direct;
  assign pop     = drain & ~bus.fifo_full & ~skid_empty;

  router_skid_buf #(
    .DATA_W     (DATA_W),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .pop_i      (pop),
    .wdata_i    (bus.data_in),
    .rdata_o    (skid_rdata),
    .count_o    (skid_count),
    .empty_o    (skid_empty),
    .overflow_o (skid_ovf)
  );

  // Select which byte, if any, is written to the FIFO this cycle
  always_comb begin
    dout_src = SRC_NONE;
    if (bus.lfd_state) begin
      dout_src = SRC_HDR;
    end else if (direct) begin
      dout_src = SRC_DIRECT;
    end else if (pop) begin
      dout_src = SRC_SKID;
    end
  end

  // Next-state for header, accumulator, length counter and status flags
  always_comb begin
    hdr_d           = hdr_q;
    pkt_par_d       = pkt_par_q;
    acc_d           = acc_q;
    len_d           = len_q;
    chk_pend_d      = 1'b0;
    dout_d          = dout_q;
    dout_we_d       = 1'b0;
    parity_done_d   = 1'b0;
    low_pkt_valid_d = low_pkt_valid_q;
    error_d         = error_q;
    len_error_d     = len_error_q;

    unique case (dout_src)
      SRC_HDR: begin
        dout_d    = hdr_q;
        dout_we_d = 1'b1;
      end
      SRC_DIRECT: begin
        dout_d    = bus.data_in;
        dout_we_d = 1'b1;
      end
      SRC_SKID: begin
        dout_d    = skid_rdata;
        dout_we_d = 1'b1;
      end
      default: begin
      end
    endcase

    if (bus.lfd_state) begin
      acc_d = fold(acc_q, hdr_q);
    end

    // Every payload byte counts, including one dropped on skid overflow
    if (ld_byte) begin
      acc_d = fold(acc_q, bus.data_in);
      if (len_q != '1) begin
        len_d = len_q + LEN_W'(1);
      end
    end

    // Parity byte: latched only, the check runs on the following cycle
    if (ld_par) begin
      pkt_par_d  = bus.data_in;
      chk_pend_d = 1'b1;
    end

    if (chk_pend_q) begin
      parity_done_d = 1'b1;
      if (!par_ok(PARITY_MODE, FOLD_W'(acc_q), FOLD_W'(pkt_par_q))) begin
        error_d = 1'b1;
      end
      if (len_q != hdr_q[DATA_W-1:LEN_LSB]) begin
        len_error_d = 1'b1;
      end
    end

    if (skid_ovf) begin
      error_d = 1'b1;
    end

    // Set has priority over the FSM's clear
    if (bus.rst_int_reg) begin
      low_pkt_valid_d = 1'b0;
    end
    if (ld_par) begin
      low_pkt_valid_d = 1'b1;
    end

    // A new header starts a fresh packet check
    if (hdr_cap) begin
      hdr_d         = bus.data_in;
      acc_d         = '0;
      len_d         = '0;
      error_d       = 1'b0;
      len_error_d   = 1'b0;
      parity_done_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      hdr_q           <= '0;
      pkt_par_q       <= '0;
      acc_q           <= '0;
      len_q           <= '0;
      chk_pend_q      <= 1'b0;
      dout_q          <= '0;
      dout_we_q       <= 1'b0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      error_q         <= 1'b0;
      len_error_q     <= 1'b0;
    end else begin
      hdr_q           <= hdr_d;
      pkt_par_q       <= pkt_par_d;
      acc_q           <= acc_d;
      len_q           <= len_d;
      chk_pend_q      <= chk_pend_d;
      dout_q          <= dout_d;
      dout_we_q       <= dout_we_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      error_q         <= error_d;
      len_error_q     <= len_error_d;
    end
  end

  assign bus.dout          = dout_q;
  assign bus.dout_we       = dout_we_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;
  assign bus.error         = error_q;
  assign bus.len_error     = len_error_q;
  assign bus.skid_count    = skid_count;

endmodule

// File: tb/tb_router_reg_param.sv
// Bench for router_reg_param: an XOR-mode and a SUM-mode instance see the
// same stimulus; a scoreboard checks every FIFO write of both, and each
// scenario task checks flags and skid occupancy inline.
module tb_router_reg_param;

  localparam int DW = 8;
  localparam int SD = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          pkt_valid, fifo_full, rst_int_reg, detect_add;
  logic          ld_state, laf_state, full_state, lfd_state;
  logic [DW-1:0] data_in;

  router_reg_param_if #(.DATA_W(DW), .SKID_DEPTH(SD)) if0 ();
  router_reg_param_if #(.DATA_W(DW), .SKID_DEPTH(SD)) if1 ();

  assign if0.pkt_valid   = pkt_valid;
  assign if0.data_in     = data_in;
  assign if0.fifo_full   = fifo_full;
  assign if0.rst_int_reg = rst_int_reg;
  assign if0.detect_add  = detect_add;
  assign if0.ld_state    = ld_state;
  assign if0.laf_state   = laf_state;
  assign if0.full_state  = full_state;
  assign if0.lfd_state   = lfd_state;
  assign if1.pkt_valid   = pkt_valid;
  assign if1.data_in     = data_in;
  assign if1.fifo_full   = fifo_full;
  assign if1.rst_int_reg = rst_int_reg;
  assign if1.detect_add  = detect_add;
  assign if1.ld_state    = ld_state;
  assign if1.laf_state   = laf_state;
  assign if1.full_state  = full_state;
  assign if1.lfd_state   = lfd_state;

  router_reg_param #(.DATA_W(DW), .SKID_DEPTH(SD), .PARITY_MODE(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  router_reg_param #(.DATA_W(DW), .SKID_DEPTH(SD), .PARITY_MODE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] skid_m[$];
  logic [7:0] e0, e1;

  // Scoreboard: every FIFO write must match the oldest expected byte
  always @(negedge clk) begin
    if (if0.dout_we === 1'b1) begin
      n_cmp++;
      if (exp_q0.size() == 0) begin
        n_bad++;
        $display("FAIL dout0_unexpected: got %h with no write expected", if0.dout);
      end else begin
        e0 = exp_q0.pop_front();
        if (if0.dout !== e0) begin
          n_bad++;
          $display("FAIL dout0: got %h, required %h", if0.dout, e0);
        end else begin
          $display("dout0 write %h", if0.dout);
        end
      end
    end
    if (if1.dout_we === 1'b1) begin
      n_cmp++;
      if (exp_q1.size() == 0) begin
        n_bad++;
        $display("FAIL dout1_unexpected: got %h with no write expected", if1.dout);
      end else begin
        e1 = exp_q1.pop_front();
        if (if1.dout !== e1) begin
          n_bad++;
          $display("FAIL dout1: got %h, required %h", if1.dout, e1);
        end else begin
          $display("dout1 write %h", if1.dout);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pkt_valid   = 1'b0;
    data_in     = '0;
    fifo_full   = 1'b0;
    rst_int_reg = 1'b0;
    detect_add  = 1'b0;
    ld_state    = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
    lfd_state   = 1'b0;
  endtask

  task automatic exp_push(input logic [7:0] b);
    exp_q0.push_back(b);
    exp_q1.push_back(b);
  endtask

  task automatic drv_hdr(input logic [7:0] h);
    idle();
    detect_add = 1'b1;
    pkt_valid  = 1'b1;
    data_in    = h;
    cyc();
  endtask

  task automatic drv_lfd(input logic [7:0] h);
    idle();
    lfd_state = 1'b1;
    exp_push(h);
    cyc();
  endtask

  // Payload byte; the bench's own view of where the byte should go
  task automatic drv_byte(input logic [7:0] b, input logic ff);
    idle();
    ld_state  = 1'b1;
    pkt_valid = 1'b1;
    data_in   = b;
    fifo_full = ff;
    if (!ff && skid_m.size() == 0) exp_push(b);
    else if (skid_m.size() < SD) skid_m.push_back(b);
    cyc();
  endtask

  task automatic drv_par(input logic [7:0] p, input logic clr);
    idle();
    ld_state    = 1'b1;
    data_in     = p;
    rst_int_reg = clr;
    cyc();
  endtask

  task automatic drv_drain();
    idle();
    laf_state = 1'b1;
    if (skid_m.size() > 0) exp_push(skid_m.pop_front());
    cyc();
  endtask

  task automatic send_pkt3(input logic [7:0] h, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] p);
    drv_hdr(h);
    drv_lfd(h);
    drv_byte(b0, 1'b0);
    drv_byte(b1, 1'b0);
    drv_byte(b2, 1'b0);
    drv_par(p, 1'b0);
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    cyc();
    cyc();
    n_cmp++;
    if ({if0.dout, if0.dout_we, if0.parity_done, if0.low_pkt_valid, if0.error, if0.len_error, if0.skid_count} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset0: got dout=%h we=%b pd=%b lpv=%b err=%b lerr=%b cnt=%0d, required all 0",
               if0.dout, if0.dout_we, if0.parity_done, if0.low_pkt_valid, if0.error, if0.len_error, if0.skid_count);
    end
    n_cmp++;
    if ({if1.dout, if1.dout_we, if1.parity_done, if1.low_pkt_valid, if1.error, if1.len_error, if1.skid_count} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset1: got dout=%h we=%b pd=%b lpv=%b err=%b lerr=%b cnt=%0d, required all 0",
               if1.dout, if1.dout_we, if1.parity_done, if1.low_pkt_valid, if1.error, if1.len_error, if1.skid_count);
    end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_good_xor();
    logic [7:0] p;
    p = 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33;
    send_pkt3(8'h0D, 8'h11, 8'h22, 8'h33, p);
    n_cmp++;
    if (if0.low_pkt_valid !== 1'b1 || if0.parity_done !== 1'b0) begin
      n_bad++;
      $display("FAIL good_par_latch: got lpv=%b pd=%b, required lpv=1 pd=0", if0.low_pkt_valid, if0.parity_done);
    end
    idle();
    cyc();
    n_cmp++;
    if ({if0.parity_done, if0.error, if0.len_error} !== 3'b100) begin
      n_bad++;
      $display("FAIL good_check: got pd/err/lerr=%b, required 100", {if0.parity_done, if0.error, if0.len_error});
    end
    idle();
    rst_int_reg = 1'b1;
    cyc();
    n_cmp++;
    if (if0.parity_done !== 1'b0 || if0.low_pkt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL good_after: got pd=%b lpv=%b, required 0 0", if0.parity_done, if0.low_pkt_valid);
    end
  endtask

  task automatic test_bad_parity();
    logic [7:0] p;
    p = (8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33) ^ 8'h01;
    drv_hdr(8'h0D);
    drv_lfd(8'h0D);
    drv_byte(8'h11, 1'b0);
    drv_byte(8'h22, 1'b0);
    drv_byte(8'h33, 1'b0);
    // Clear strobe coincides with the set: set must win
    drv_par(p, 1'b1);
    n_cmp++;
    if (if0.low_pkt_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL lpv_set_wins: got %b, required 1", if0.low_pkt_valid);
    end
    idle();
    cyc();
    n_cmp++;
    if ({if0.parity_done, if0.error} !== 2'b11) begin
      n_bad++;
      $display("FAIL bad_par: got pd/err=%b, required 11", {if0.parity_done, if0.error});
    end
    for (int i = 0; i < 3; i++) cyc();
    n_cmp++;
    if ({if0.parity_done, if0.error} !== 2'b01) begin
      n_bad++;
      $display("FAIL err_sticky: got pd/err=%b, required 01", {if0.parity_done, if0.error});
    end
  endtask

  task automatic test_len();
    logic [7:0] p;
    p = 8'h11 ^ 8'h11 ^ 8'h22 ^ 8'h33;
    drv_hdr(8'h11);
    n_cmp++;
    if ({if0.error, if0.len_error} !== 2'b00) begin
      n_bad++;
      $display("FAIL hdr_clear: got err/lerr=%b, required 00", {if0.error, if0.len_error});
    end
    drv_lfd(8'h11);
    drv_byte(8'h11, 1'b0);
    drv_byte(8'h22, 1'b0);
    drv_byte(8'h33, 1'b0);
    drv_par(p, 1'b0);
    idle();
    cyc();
    n_cmp++;
    if ({if0.parity_done, if0.error, if0.len_error} !== 3'b101) begin
      n_bad++;
      $display("FAIL len_err: got pd/err/lerr=%b, required 101", {if0.parity_done, if0.error, if0.len_error});
    end
  endtask

  task automatic test_skid();
    drv_hdr(8'h0A);
    drv_lfd(8'h0A);
    drv_byte(8'hA1, 1'b1);
    n_cmp++;
    if (if0.skid_count !== 2'd1 || if0.dout_we !== 1'b0) begin
      n_bad++;
      $display("FAIL skid_push1: got cnt=%0d we=%b, required 1 0", if0.skid_count, if0.dout_we);
    end
    drv_byte(8'hA2, 1'b1);
    n_cmp++;
    if (if0.skid_count !== 2'd2) begin
      n_bad++;
      $display("FAIL skid_push2: got cnt=%0d, required 2", if0.skid_count);
    end
    drv_drain();
    n_cmp++;
    if (if0.skid_count !== 2'd1) begin
      n_bad++;
      $display("FAIL skid_pop1: got cnt=%0d, required 1", if0.skid_count);
    end
    drv_drain();
    n_cmp++;
    if (if0.skid_count !== 2'd0) begin
      n_bad++;
      $display("FAIL skid_pop2: got cnt=%0d, required 0", if0.skid_count);
    end
    drv_par(8'h0A ^ 8'hA1 ^ 8'hA2, 1'b0);
    idle();
    cyc();
    n_cmp++;
    if ({if0.parity_done, if0.error, if0.len_error} !== 3'b100) begin
      n_bad++;
      $display("FAIL skid_check: got pd/err/lerr=%b, required 100", {if0.parity_done, if0.error, if0.len_error});
    end
  endtask

  task automatic test_overflow();
    drv_hdr(8'h0E);
    drv_lfd(8'h0E);
    drv_byte(8'hB1, 1'b1);
    drv_byte(8'hB2, 1'b1);
    drv_byte(8'hB3, 1'b1);
    n_cmp++;
    if (if0.skid_count !== 2'd2 || if0.error !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf: got cnt=%0d err=%b, required 2 1", if0.skid_count, if0.error);
    end
    drv_drain();
    drv_drain();
    drv_drain();
    n_cmp++;
    if (if0.skid_count !== 2'd0 || if0.dout_we !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_empty_pop: got cnt=%0d we=%b, required 0 0", if0.skid_count, if0.dout_we);
    end
    drv_par(8'h0E ^ 8'hB1 ^ 8'hB2 ^ 8'hB3, 1'b0);
    idle();
    cyc();
    n_cmp++;
    if ({if0.parity_done, if0.error, if0.len_error} !== 3'b110) begin
      n_bad++;
      $display("FAIL ovf_check: got pd/err/lerr=%b, required 110", {if0.parity_done, if0.error, if0.len_error});
    end
  endtask

  task automatic test_sum_reset();
    logic [7:0] p;
    drv_hdr(8'h0D);
    drv_lfd(8'h0D);
    drv_byte(8'h11, 1'b0);
    drv_byte(8'h22, 1'b1);
    idle();
    rst = 1'b0;
    skid_m.delete();
    cyc();
    rst = 1'b1;
    n_cmp++;
    if ({if1.dout, if1.dout_we, if1.parity_done, if1.low_pkt_valid, if1.error, if1.len_error, if1.skid_count} !== 15'd0) begin
      n_bad++;
      $display("FAIL midreset1: got dout=%h we=%b pd=%b lpv=%b err=%b lerr=%b cnt=%0d, required all 0",
               if1.dout, if1.dout_we, if1.parity_done, if1.low_pkt_valid, if1.error, if1.len_error, if1.skid_count);
    end
    n_cmp++;
    if ({if0.dout, if0.skid_count} !== 10'd0) begin
      n_bad++;
      $display("FAIL midreset0: got dout=%h cnt=%0d, required 0 0", if0.dout, if0.skid_count);
    end
    p = 8'(8'h0D + 8'h11 + 8'h22 + 8'h33);
    send_pkt3(8'h0D, 8'h11, 8'h22, 8'h33, p);
    idle();
    cyc();
    n_cmp++;
    if ({if1.parity_done, if1.error, if1.len_error} !== 3'b100) begin
      n_bad++;
      $display("FAIL sum_check: got pd/err/lerr=%b, required 100", {if1.parity_done, if1.error, if1.len_error});
    end
    // The XOR instance must reject the sum parity byte
    n_cmp++;
    if ({if0.parity_done, if0.error} !== 2'b11) begin
      n_bad++;
      $display("FAIL xor_rejects_sum: got pd/err=%b, required 11", {if0.parity_done, if0.error});
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_good_xor();
    test_bad_parity();
    test_len();
    test_skid();
    test_overflow();
    test_sum_reset();
    idle();
    cyc();
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d/%0d writes missing, required 0", exp_q0.size(), exp_q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
